// File: rtl/monitor_scheduler.sv
// -----------------------------------------------------------------------------
// monitor_scheduler
//
// Stream-monitor scheduler. Input-stream events and periodic ticks are
// time-stamped and queued; a small FSM pops one entry at a time and issues the
// evaluate (pacing) and window-slide strobes for it:
//   IDLE -> POP -> L0 [-> L1] -> IDLE
// L0 serves the event streams and the sliding windows. L1 serves the periodic
// output stream and is visited only for entries that carry a tick.
//
// Build option:
//   SCHED_DROP_COUNT_EN  defined   : drop_cnt counts dropped entries, saturating
//                        undefined : drop_cnt is tied to zero
//
// Parameters:
//   PERIOD  clock cycles between periodic ticks (2..65535)
//   QDEPTH  event-queue depth, power of two (2..16)
//
// Ports:
//   clk           clock, rising edge
//   rst           asynchronous active-low reset; release is synchronised here
//   en            global enable; when low all state holds and strobes read 0
//   new_input     per-input-stream event strobes
//   q_push        push attempt (event or tick this cycle)
//   q_push_valid  push accepted (queue not full)
//   q_pop         entry popped from the queue
//   q_pop_valid   popped entry is valid
//   pacing        evaluate strobes, output streams 0..3
//   slide         window-slide strobes, windows 0..2
//   busy          FSM is not IDLE
//   ev_time       timestamp of the entry being evaluated
//   overflow      sticky: an entry has been dropped
//   drop_cnt      dropped-entry counter
// -----------------------------------------------------------------------------
module monitor_scheduler #(
  parameter int PERIOD = 1000,
  parameter int QDEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [2:0]  new_input,
  output logic        q_push,
  output logic        q_pop,
  output logic        q_push_valid,
  output logic        q_pop_valid,
  output logic [3:0]  pacing,
  output logic [2:0]  slide,
  output logic        busy,
  output logic [63:0] ev_time,
  output logic        overflow,
  output logic [15:0] drop_cnt
);

  localparam int AW = $clog2(QDEPTH);
  localparam int TW = $clog2(PERIOD);

  typedef enum logic [1:0] {IDLE, POP, L0, L1} state_t;

  // kind[0] = event, kind[1] = periodic
  typedef struct packed {
    logic [1:0]  kind;
    logic [2:0]  mask;
    logic [63:0] t;
  } entry_t;

  // Reset assertion is immediate; release takes two edges, and nothing advances
  // until the synchroniser output is high.
  logic [1:0] rst_sync;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync <= '0;
    else      rst_sync <= {rst_sync[0], 1'b1};
  end

  logic active;
  assign active = en & rst_sync[1];

  // ---------------------------------------------------------------------------
  // Time base and tick generator
  // ---------------------------------------------------------------------------
  logic [63:0]   time_cnt;
  logic [TW-1:0] tick_cnt;
  logic          tick;

  assign tick = active && (tick_cnt == TW'(PERIOD - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      time_cnt <= '0;
      tick_cnt <= '0;
    end else if (active) begin
      time_cnt <= time_cnt + 64'd1;
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Event queue
  // ---------------------------------------------------------------------------
  entry_t        mem [QDEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          empty, full, drop;
  entry_t        new_entry;
  state_t        state;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A coincident event and tick share one entry.
  assign new_entry    = '{kind: {tick, |new_input}, mask: new_input, t: time_cnt};
  assign q_push       = active && ((|new_input) || tick);
  // Fullness is judged before any same-cycle pop frees a slot.
  assign q_push_valid = q_push && !full;
  assign drop         = q_push && full;
  assign q_pop        = active && (state == POP);
  assign q_pop_valid  = q_pop && !empty;

  // NOTE: the storage array has no reset; only the pointers define which
  // entries are live, so clearing the contents would add logic for nothing.
  always_ff @(posedge clk) begin
    if (q_push_valid) mem[wr_ptr[AW-1:0]] <= new_entry;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (q_push_valid) wr_ptr <= wr_ptr + 1'b1;
      if (q_pop_valid)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Evaluation FSM
  // ---------------------------------------------------------------------------
  logic [1:0] cur_kind;
  logic [2:0] cur_mask;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cur_kind <= '0;
      cur_mask <= '0;
      ev_time  <= '0;
    end else if (active) begin
      case (state)
        // Looking at this cycle's accepted push gives POP one cycle after it.
        IDLE: if (!empty || q_push_valid) state <= POP;
        POP: begin
          cur_kind <= mem[rd_ptr[AW-1:0]].kind;
          cur_mask <= mem[rd_ptr[AW-1:0]].mask;
          ev_time  <= mem[rd_ptr[AW-1:0]].t;
          state    <= L0;
        end
        L0:      state <= cur_kind[1] ? L1 : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

  // Strobes decode the registered state; gating with active keeps them at zero
  // while frozen so a held strobe is issued once, on resume.
  // NOTE: every output of this block gets a default first, so no latch forms.
  always_comb begin
    pacing = '0;
    slide  = '0;
    if (active) begin
      case (state)
        L0: begin
          pacing[2:0] = cur_kind[0] ? cur_mask : 3'b000;
          slide       = cur_kind[1] ? 3'b111 : 3'b000;
        end
        L1:      pacing[3] = 1'b1;
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Drop reporting
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      overflow <= 1'b0;
    else if (drop) overflow <= 1'b1;
  end

`ifdef SCHED_DROP_COUNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                              drop_cnt <= '0;
    else if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
  end
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_monitor_scheduler.sv
// -----------------------------------------------------------------------------
// Testbench for monitor_scheduler. A cycle monitor keeps a queue of expected
// entries (pushed when stimulus creates them, popped when the DUT pops) and
// checks pushes, pops, strobes and drop flags every cycle; scenario tasks add
// directed timing checks.
// -----------------------------------------------------------------------------
module tb_monitor_scheduler;

  localparam int PERIOD = 1000;
  localparam int QDEPTH = 4;

  typedef struct packed {
    logic [1:0]  kind;
    logic [2:0]  mask;
    logic [63:0] t;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst, en;
  logic [2:0]  new_input;
  logic        q_push, q_pop, q_push_valid, q_pop_valid;
  logic [3:0]  pacing;
  logic [2:0]  slide;
  logic        busy;
  logic [63:0] ev_time;
  logic        overflow;
  logic [15:0] drop_cnt;

  monitor_scheduler #(.PERIOD(PERIOD), .QDEPTH(QDEPTH)) dut (
    .clk(clk), .rst(rst), .en(en), .new_input(new_input),
    .q_push(q_push), .q_pop(q_pop), .q_push_valid(q_push_valid),
    .q_pop_valid(q_pop_valid), .pacing(pacing), .slide(slide), .busy(busy),
    .ev_time(ev_time), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  ent_t        sb[$];
  ent_t        cur;
  int          stage = 0;   // 0 idle/pop, 1 expect L0, 2 expect L1, 3 expect idle
  logic [63:0] mtime = '0;
  int          mtick = 0;
  int          mdrop = 0;
  logic        movf = 1'b0;
  int          rel_cnt = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst)             rel_cnt <= 0;
    else if (rel_cnt < 2) rel_cnt <= rel_cnt + 1;
  end

  always @(negedge clk) begin
    logic tick, exp_push, exp_pop, exp_full, eb;
    logic [3:0]  ep;
    logic [2:0]  es;
    logic [15:0] exp_drop;
    if (!rst) begin
      total++;
      if ({pacing, slide, busy, q_push, q_pop, q_push_valid, q_pop_valid, overflow} !== '0
          || ev_time !== 64'd0 || drop_cnt !== 16'd0) begin
        bad++;
        $display("FAIL reset_outputs: pacing=%b slide=%b busy=%b q=%b%b%b%b ovf=%b ev_time=%0d drop=%0d, want all 0",
                 pacing, slide, busy, q_push, q_pop, q_push_valid, q_pop_valid, overflow, ev_time, drop_cnt);
      end
      sb.delete(); stage = 0; mtime = '0; mtick = 0; mdrop = 0; movf = 1'b0;
    end else if (!(en && rel_cnt >= 2)) begin
      total++;
      if ({q_push, q_pop, q_push_valid, q_pop_valid, pacing, slide} !== '0) begin
        bad++;
        $display("FAIL frozen_outputs: q=%b%b%b%b pacing=%b slide=%b, want 0",
                 q_push, q_pop, q_push_valid, q_pop_valid, pacing, slide);
      end
    end else begin
      tick     = (mtick == PERIOD - 1);
      exp_push = (new_input != 3'b000) || tick;
      exp_pop  = (stage == 0) && (sb.size() != 0);
      exp_full = (sb.size() >= QDEPTH);
`ifdef SCHED_DROP_COUNT_EN
      exp_drop = 16'(mdrop);
`else
      exp_drop = 16'd0;
`endif
      total++;
      if (q_push !== exp_push || q_push_valid !== (exp_push && !exp_full)) begin
        bad++;
        $display("FAIL push t=%0d: q_push=%b q_push_valid=%b, want %b %b",
                 mtime, q_push, q_push_valid, exp_push, exp_push && !exp_full);
      end
      total++;
      if (q_pop !== exp_pop || q_pop_valid !== exp_pop) begin
        bad++;
        $display("FAIL pop t=%0d: q_pop=%b q_pop_valid=%b, want %b", mtime, q_pop, q_pop_valid, exp_pop);
      end
      total++;
      if (overflow !== movf || drop_cnt !== exp_drop) begin
        bad++;
        $display("FAIL drop_flags t=%0d: overflow=%b drop_cnt=%0d, want %b %0d",
                 mtime, overflow, drop_cnt, movf, exp_drop);
      end
      ep = 4'b0000; es = 3'b000; eb = 1'b0;
      case (stage)
        0: eb = exp_pop;
        1: begin
          ep = {1'b0, cur.kind[0] ? cur.mask : 3'b000};
          es = cur.kind[1] ? 3'b111 : 3'b000;
          eb = 1'b1;
        end
        2: begin ep = 4'b1000; eb = 1'b1; end
        default: ;
      endcase
      total++;
      if (pacing !== ep || slide !== es || busy !== eb) begin
        bad++;
        $display("FAIL strobes t=%0d stage=%0d: pacing=%b slide=%b busy=%b, want %b %b %b",
                 mtime, stage, pacing, slide, busy, ep, es, eb);
      end
      if (stage == 1) begin
        total++;
        if (ev_time !== cur.t) begin
          bad++;
          $display("FAIL ev_time: got %0d want %0d", ev_time, cur.t);
        end
      end
      if (exp_push) begin
        if (!exp_full) sb.push_back('{kind: {tick, new_input != 3'b000}, mask: new_input, t: mtime});
        else begin
          if (mdrop < 65535) mdrop++;
          movf = 1'b1;
        end
      end
      case (stage)
        1:       stage = cur.kind[1] ? 2 : 3;
        2:       stage = 3;
        default: stage = 0;
      endcase
      if (exp_pop) begin
        cur   = sb.pop_front();
        stage = 1;
      end
      mtime = mtime + 64'd1;
      mtick = tick ? 0 : mtick + 1;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b0; new_input = 3'b000;
    repeat (3) @(negedge clk);
    total++;
    if ({pacing, slide, busy, q_pop, q_pop_valid, overflow} !== '0 || ev_time !== 64'd0) begin
      bad++;
      $display("FAIL test_reset: pacing=%b slide=%b busy=%b ev_time=%0d, want 0", pacing, slide, busy, ev_time);
    end
    step(); rst = 1'b1; en = 1'b1;
  endtask

  task automatic test_event_latency();
    int n = 0;
    step();
    while (mtime != 64'd50 && n < 200) begin step(); n++; end
    total++;
    if (mtime != 64'd50) begin bad++; $display("FAIL latency_timeout: t=%0d want 50", mtime); end
    new_input = 3'b101;
    @(negedge clk); total++;
    if (q_push_valid !== 1'b1) begin bad++; $display("FAIL latency_push: q_push_valid=%b want 1", q_push_valid); end
    step(); new_input = 3'b000;
    @(negedge clk); total++;
    if (q_pop !== 1'b1) begin bad++; $display("FAIL latency_pop: q_pop=%b want 1", q_pop); end
    @(negedge clk); total++;
    if (pacing !== 4'b0101) begin bad++; $display("FAIL latency_pacing: pacing=%b want 0101", pacing); end
    @(negedge clk); total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL latency_busy: busy=%b want 0", busy); end
  endtask

  task automatic test_periodic();
    logic [63:0] exp_t [2] = '{64'd999, 64'd1999};
    int found = 0;
    int n = 0;
    while (found < 2 && n < 2500) begin
      @(negedge clk); n++;
      if (slide === 3'b111) begin
        total++;
        if (ev_time !== exp_t[found] || pacing !== 4'b0000) begin
          bad++;
          $display("FAIL periodic_l0: ev_time=%0d pacing=%b, want %0d 0000", ev_time, pacing, exp_t[found]);
        end
        @(negedge clk); total++;
        if (pacing !== 4'b1000 || slide !== 3'b000) begin
          bad++;
          $display("FAIL periodic_l1: pacing=%b slide=%b, want 1000 000", pacing, slide);
        end
        found++;
      end
    end
    total++;
    if (found != 2) begin bad++; $display("FAIL periodic_timeout: found %0d want 2", found); end
  endtask

  task automatic test_coincident();
    logic [63:0] t_drive;
    int n = 0;
    step();
    while (mtick != PERIOD - 1 && n < 1500) begin step(); n++; end
    t_drive   = mtime;
    new_input = 3'b010;
    @(negedge clk); total++;
    if (q_push_valid !== 1'b1) begin bad++; $display("FAIL coinc_push: q_push_valid=%b want 1", q_push_valid); end
    step(); new_input = 3'b000;
    @(negedge clk); total++;
    if (q_pop !== 1'b1) begin bad++; $display("FAIL coinc_pop: q_pop=%b want 1", q_pop); end
    @(negedge clk); total++;
    if (pacing !== 4'b0010 || slide !== 3'b111 || ev_time !== t_drive) begin
      bad++;
      $display("FAIL coinc_l0: pacing=%b slide=%b ev_time=%0d, want 0010 111 %0d", pacing, slide, ev_time, t_drive);
    end
    @(negedge clk); total++;
    if (pacing !== 4'b1000 || slide !== 3'b000) begin
      bad++;
      $display("FAIL coinc_l1: pacing=%b slide=%b, want 1000 000", pacing, slide);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] masks [8] = '{3'b001, 3'b010, 3'b100, 3'b011, 3'b110, 3'b111, 3'b101, 3'b001};
    int n = 0;
    logic [15:0] exp_drop;
    step();
    for (int i = 0; i < 8; i++) begin
      new_input = masks[i];
      step();
    end
    new_input = 3'b000;
    while ((sb.size() != 0 || stage != 0) && n < 200) begin @(negedge clk); n++; end
    @(negedge clk);
`ifdef SCHED_DROP_COUNT_EN
    exp_drop = 16'(mdrop);
`else
    exp_drop = 16'd0;
`endif
    total++;
    if (overflow !== 1'b1 || drop_cnt !== exp_drop || mdrop == 0 || n >= 200) begin
      bad++;
      $display("FAIL back_to_back: overflow=%b drop_cnt=%0d model_drops=%0d want overflow 1 drop_cnt %0d",
               overflow, drop_cnt, mdrop, exp_drop);
    end
  endtask

  task automatic test_en_low();
    step(); new_input = 3'b100;
    @(negedge clk);
    step(); new_input = 3'b000; en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); total++;
      if (q_pop !== 1'b0 || pacing !== 4'b0000) begin
        bad++;
        $display("FAIL en_low_hold: q_pop=%b pacing=%b want 0 0000", q_pop, pacing);
      end
      step();
    end
    en = 1'b1;
    @(negedge clk); total++;
    if (q_pop !== 1'b1) begin bad++; $display("FAIL en_resume_pop: q_pop=%b want 1", q_pop); end
    @(negedge clk); total++;
    if (pacing !== 4'b0100) begin bad++; $display("FAIL en_resume_l0: pacing=%b want 0100", pacing); end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    do begin @(negedge clk); n++; end while (slide !== 3'b111 && n < 1500);
    total++;
    if (slide !== 3'b111) begin bad++; $display("FAIL reset_mid_timeout: slide=%b want 111", slide); end
    #2 rst = 1'b0;
    #1 total++;
    if ({pacing, slide, busy, q_pop} !== '0 || ev_time !== 64'd0) begin
      bad++;
      $display("FAIL reset_mid_async: pacing=%b slide=%b busy=%b q_pop=%b ev_time=%0d, want 0",
               pacing, slide, busy, q_pop, ev_time);
    end
    step(); step(); rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); total++;
      if (pacing !== 4'b0000 || busy !== 1'b0 || overflow !== 1'b0 || drop_cnt !== 16'd0) begin
        bad++;
        $display("FAIL reset_mid_after: pacing=%b busy=%b overflow=%b drop_cnt=%0d, want 0",
                 pacing, busy, overflow, drop_cnt);
      end
    end
    step(); new_input = 3'b011;
    step(); new_input = 3'b000;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_event_latency();
    test_periodic();
    test_coincident();
    test_back_to_back();
    test_en_low();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
